pic_interrupt_sequencer: RTL
============================

# pic_interrupt_sequencer

Interrupt sequencer for the 8259-compatible PIC: resolves priority among pending requests from the IRR, qualified by the IMR and the in-service register it owns. It raises INT to the CPU and sequences the two-pulse INTA acknowledge cycle. It clears the serviced IRR bit through the IRR's `clear_IRR` port and drives the 8086-mode interrupt vector. It also maintains the ISR under EOI commands.

## Interface
- No parameters.
- `clk` input 1: system clock; all state updates on rising edge.
- `reset` input 1: synchronous, active-high reset.
- `irr` input 8: pending requests from the IRR's `IRR_Output`; bit 0 = IR0.
- `imr` input 8: interrupt mask; 1 = level masked.
- `inta` input 1: single-cycle acknowledge strobe, one per CPU INTA pulse, already synchronised.
- `eoi` input 1: single-cycle EOI command strobe.
- `eoi_specific` input 1: qualifies `eoi`; 1 = specific EOI, 0 = non-specific.
- `eoi_level` input 3: level cleared by a specific EOI.
- `vector_base` input 5: ICW2 bits T7..T3.
- `int_out` output 1: interrupt request to CPU.
- `clear_irr` output 8: one-hot, one-cycle clear pulse to the IRR's `clear_IRR`.
- `isr` output 8: in-service register.
- `data_out` output 8: vector byte.
- `data_oe` output 1: `data_out` valid/drive enable.

## Operation
- Eligible set: `irr & ~imr`, restricted to levels of strictly higher priority than the highest set `isr` bit.
  - Fixed priority with full nesting: IR0 highest, IR7 lowest.
- Winner: lowest-numbered eligible bit.
- FSM states: IDLE, PENDING, ACK1.
- IDLE:
  - If an eligible request exists, go to PENDING and set `int_out`=1.
  - `inta` is ignored in IDLE.
- PENDING, eligible set becomes empty before `inta`: deassert `int_out` and return to IDLE.
- PENDING, `inta` with a winner:
  - Latch the winner level L.
  - Set `isr[L]`.
  - Pulse `clear_irr[L]`.
  - Set `int_out`=0 and go to ACK1.
- PENDING, `inta` with no eligible request (spurious):
  - Latch L=7.
  - No ISR set and no `clear_irr` pulse.
  - Go to ACK1.
- ACK1, `inta`:
  - Set `data_out`={`vector_base`,L} and `data_oe`=1.
  - Return to IDLE.
- EOI handling:
  - Non-specific `eoi` clears the highest-priority set `isr` bit.
  - Specific `eoi` clears `isr[eoi_level]`.
  - EOI with `isr` empty has no effect.
  - EOI is accepted in any state.
- ISR update rule: `isr_next = (isr & ~eoi_clear) | inta_set`. A set wins if both target the same bit.
- IRR changes after L is latched do not alter the vector.

## Timing
- Reset values:
  - `int_out`=0, `clear_irr`=0, `isr`=0, `data_out`=0, `data_oe`=0.
  - State=IDLE, L=0.
- Reset asserted mid-cycle (any state) aborts the sequence next edge; no `clear_irr` pulse is issued.
- `int_out` rises on the edge after an eligible request is sampled in IDLE (1-cycle latency).
- `int_out` falls on the edge sampling the first `inta`, or on the edge after the eligible set empties.
- `clear_irr` and the `isr` set are both registered: they become visible the cycle after the first `inta` and last exactly 1 cycle for `clear_irr`.
- `data_oe` is high exactly one cycle: the cycle after the second `inta`. `data_out` holds its value until the next vector.
- Back-to-back: a new eligible request may raise `int_out` on the edge after returning to IDLE. The minimum gap between ACK1 exit and a new `int_out` is 1 cycle.
- EOI takes effect on the next edge. A request unblocked by EOI raises `int_out` one cycle after `isr` updates.

## Configuration
- `AUTO_EOI_EN`:
  - When defined, the second `inta` clears `isr[L]` on the same edge that asserts `data_oe`. ISR is therefore non-zero only between the two INTA strobes. The `eoi` input remains functional.
  - When undefined, ISR bits clear only via `eoi`.
  - The spurious path is unaffected either way.

## Test plan
- `irr`=8'b00010010, `imr`=0, `vector_base`=5'b01000:
  - `int_out` rises after 1 cycle.
  - First `inta` → `clear_irr`=8'b00000010, `isr`=8'b00000010.
  - Second `inta` → `data_out`=8'h41, `data_oe` for 1 cycle.
- With `isr`=8'b00000010 and `irr`=8'b00010000: `int_out` stays 0. A non-specific `eoi` clears `isr`, then `int_out` rises and a later ack yields `data_out`=8'h44.
- `irr`=8'b10000000, `imr`=8'b10000000: `int_out` never asserts. Clearing `imr` → `int_out` next cycle; ack → `data_out`=8'h47.
- Spurious: `irr` bit drops while PENDING, with `inta` in the same cycle → no `clear_irr`, `isr` unchanged, second `inta` → `data_out`=8'h47.
- Specific `eoi` with `eoi_level`=4 while `isr`=8'b00010010 → `isr`=8'b00000010. `reset` asserted in ACK1 → all outputs 0 next cycle and a following `inta` is ignored.
- With `AUTO_EOI_EN`: the scenario-1 sequence ends with `isr`=0 on the `data_oe` cycle.

Source files
------------

// File: rtl/pic_interrupt_sequencer.sv
// pic_interrupt_sequencer
//
// Interrupt sequencer for an 8259-compatible PIC. It resolves fixed priority
// (IR0 highest) among unmasked IRR requests, with full nesting against the
// in-service register it owns. It raises int_out, runs the two-strobe INTA
// acknowledge, pulses clear_irr for the serviced level, drives the 8086-mode
// vector {vector_base, level} and clears ISR bits on EOI commands.
//
// Optional feature: define AUTO_EOI_EN to make the second INTA strobe clear
// isr[L] on the same edge that asserts data_oe.
//
// Ports
//   clk           system clock, rising edge
//   reset         synchronous, active-high
//   irr[7:0]      pending requests, bit 0 = IR0
//   imr[7:0]      interrupt mask, 1 = masked
//   inta          one-cycle strobe per CPU INTA pulse
//   eoi           one-cycle EOI command strobe
//   eoi_specific  1 = specific EOI (uses eoi_level), 0 = non-specific
//   eoi_level     level cleared by a specific EOI
//   vector_base   ICW2 T7..T3
//   int_out       interrupt request to CPU
//   clear_irr     one-hot, one-cycle clear pulse to the IRR
//   isr[7:0]      in-service register
//   data_out      vector byte, held until the next vector
//   data_oe       data_out valid, high for one cycle
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | no request raised; waiting for an eligible level
// PENDING | int_out high; waiting for first INTA (or request withdrawal)
// ACK1    | level latched; waiting for second INTA to drive the vector

module pic_interrupt_sequencer (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] irr,
    input  logic [7:0] imr,
    input  logic       inta,
    input  logic       eoi,
    input  logic       eoi_specific,
    input  logic [2:0] eoi_level,
    input  logic [4:0] vector_base,
    output logic       int_out,
    output logic [7:0] clear_irr,
    output logic [7:0] isr,
    output logic [7:0] data_out,
    output logic       data_oe
);

`ifdef AUTO_EOI_EN
    localparam logic AUTO_EOI = 1'b1;
`else
    localparam logic AUTO_EOI = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, PENDING, ACK1} state_t;

    state_t     state, state_next;
    logic [2:0] level, level_next;
    logic       spurious, spurious_next;
    logic       int_out_next;
    logic [7:0] clear_irr_next;
    logic [7:0] isr_next;
    logic [7:0] data_out_next;
    logic       data_oe_next;

    logic [7:0] prio_mask;
    logic [7:0] eligible;
    logic       any_eligible;
    logic [2:0] winner;
    logic [7:0] eoi_clear;
    logic [7:0] inta_set;
    logic [7:0] auto_clear;

    // Only levels strictly above the highest-priority in-service level may
    // interrupt. Scanning 7 down to 0 lets the lowest set isr bit decide.
    always_comb begin
        prio_mask = 8'hff;
        for (int i = 7; i >= 0; i--) begin
            if (isr[i]) prio_mask = (8'h01 << i) - 8'h01;
        end
    end

    assign eligible     = irr & ~imr & prio_mask;
    assign any_eligible = |eligible;

    always_comb begin
        winner = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (eligible[i]) winner = 3'(i);
        end
    end

    // Non-specific EOI isolates the lowest set bit (highest priority);
    // an empty isr yields zero, so the command has no effect.
    always_comb begin
        eoi_clear = 8'h00;
        if (eoi) begin
            if (eoi_specific) eoi_clear = 8'h01 << eoi_level;
            else              eoi_clear = isr & (~isr + 8'h01);
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            level     <= 3'd0;
            spurious  <= 1'b0;
            int_out   <= 1'b0;
            clear_irr <= 8'h00;
            isr       <= 8'h00;
            data_out  <= 8'h00;
            data_oe   <= 1'b0;
        end else begin
            state     <= state_next;
            level     <= level_next;
            spurious  <= spurious_next;
            int_out   <= int_out_next;
            clear_irr <= clear_irr_next;
            isr       <= isr_next;
            data_out  <= data_out_next;
            data_oe   <= data_oe_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (any_eligible) state_next = PENDING;
            PENDING: begin
                if (inta)               state_next = ACK1;
                else if (!any_eligible) state_next = IDLE;
            end
            ACK1:    if (inta) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output / datapath next values
    always_comb begin
        level_next     = level;
        spurious_next  = spurious;
        int_out_next   = 1'b0;
        clear_irr_next = 8'h00;
        data_out_next  = data_out;
        data_oe_next   = 1'b0;
        inta_set       = 8'h00;
        auto_clear     = 8'h00;
        case (state)
            IDLE: int_out_next = any_eligible;
            PENDING: begin
                if (inta) begin
                    if (any_eligible) begin
                        level_next     = winner;
                        spurious_next  = 1'b0;
                        inta_set       = 8'h01 << winner;
                        clear_irr_next = 8'h01 << winner;
                    end else begin
                        // Request withdrew under the first INTA: report IR7.
                        level_next    = 3'd7;
                        spurious_next = 1'b1;
                    end
                end else begin
                    int_out_next = any_eligible;
                end
            end
            ACK1: begin
                if (inta) begin
                    data_out_next = {vector_base, level};
                    data_oe_next  = 1'b1;
                    if (AUTO_EOI && !spurious) auto_clear = 8'h01 << level;
                end
            end
            default: ;
        endcase
        // A set from the first INTA wins over a simultaneous clear.
        isr_next = (isr & ~(eoi_clear | auto_clear)) | inta_set;
    end

endmodule
